// File: rtl/bp_pkg.sv
// Definitions shared between the 2-bit direction predictor and its client,
// the branch resolve unit: default sizes, counter encodings, update bundle.
package bp_pkg;

  localparam int BP_DEPTH = 4;
  localparam int BP_CNT_W = 16;

  // Saturating direction counter states; the MSB is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_state_e;

  // Everything the resolve unit registers on a resolving edge.
  typedef struct packed {
    logic result;
    logic taken;
    logic mispredict;
    logic dir;
  } bru_upd_t;

  function automatic logic ctr_predict(input ctr_state_e s);
    return s[1];
  endfunction

endpackage

// File: rtl/bru_fifo.sv
// In-order DEPTH x 1-bit queue of predicted directions for in-flight branches.
// Head is read combinationally; clear wins over push and pop on the same edge.
module bru_fifo #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             din,
  input  logic             pop,
  input  logic             clear,
  output logic             head,
  output logic [PTR_W:0]   count
);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + (PTR_W+1)'(1);
        2'b01:   count_next = count_reg - (PTR_W+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage carries no reset: a slot is only read after it has been written.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (push && !clear && (wr_ptr_reg == PTR_W'(gi))) begin
          mem[gi] <= din;
        end
      end
    end
  endgenerate

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/branch_resolve_unit.sv
// Predictor client/trainer: requests predictions, queues them in order,
// trains the predictor on resolve, flags mispredicts and flushes wrong path.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int CNT_W = BP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_branch,
  output logic             fetch_ready,
  output logic             pred_request,
  input  logic             pred_in,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             upd_result,
  output logic             upd_taken,
  output logic             mispredict,
  output logic             mispredict_dir,
  output logic             protocol_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   count;
  logic             head;
  logic [PTR_W+1:0] occupancy;
  logic             resolve_ok;
  logic             resolve_empty;
  logic             flush;
  logic             capture;

  logic             pending_reg, pending_next;
  logic             perr_reg, perr_next;
  bru_upd_t         upd_reg, upd_next;
  logic [CNT_W-1:0] branch_cnt_reg, branch_cnt_next;
  logic [CNT_W-1:0] mispred_cnt_reg, mispred_cnt_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A pending prediction already owns a slot, so it counts toward occupancy.
  assign occupancy    = {1'b0, count} + {{(PTR_W+1){1'b0}}, pending_reg};
  assign fetch_ready  = occupancy < (PTR_W+2)'(DEPTH);
  assign pred_request = fetch_branch & fetch_ready;
  assign pred_valid   = pending_reg;
  assign pred_taken   = pending_reg & pred_in;

  assign resolve_ok    = resolve_valid && (count != '0);
  assign resolve_empty = resolve_valid && (count == '0);
  assign flush         = resolve_ok && (head != resolve_taken);
  // Everything younger than a mispredicted head is wrong-path, including
  // the prediction arriving this cycle.
  assign capture       = pending_reg && !flush;

  bru_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .din   (pred_in),
    .pop   (resolve_ok),
    .clear (flush),
    .head  (head),
    .count (count)
  );

  always_comb begin
    pending_next        = flush ? 1'b0 : pred_request;
    perr_next           = perr_reg | resolve_empty;
    upd_next            = '0;
    upd_next.result     = resolve_ok;
    upd_next.taken      = resolve_ok & resolve_taken;
    upd_next.mispredict = flush;
    upd_next.dir        = flush & resolve_taken;
    branch_cnt_next     = branch_cnt_reg;
    mispred_cnt_next    = mispred_cnt_reg;
    if (resolve_ok) branch_cnt_next  = sat_inc(branch_cnt_reg);
    if (flush)      mispred_cnt_next = sat_inc(mispred_cnt_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg     <= 1'b0;
      perr_reg        <= 1'b0;
      upd_reg         <= '0;
      branch_cnt_reg  <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      pending_reg     <= pending_next;
      perr_reg        <= perr_next;
      upd_reg         <= upd_next;
      branch_cnt_reg  <= branch_cnt_next;
      mispred_cnt_reg <= mispred_cnt_next;
    end
  end

  assign upd_result     = upd_reg.result;
  assign upd_taken      = upd_reg.taken;
  assign mispredict     = upd_reg.mispredict;
  assign mispredict_dir = upd_reg.dir;
  assign protocol_err   = perr_reg;
  assign branch_cnt     = branch_cnt_reg;
  assign mispred_cnt    = mispred_cnt_reg;

endmodule
